// File: rtl/serial_adder_pkg.sv
// Shared state encoding and default width for the bit-serial adder.
// Pure declarations: no logic, no latency, no flow control.
package serial_adder_pkg;

    localparam int WIDTH_DEF = 8;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

endpackage

// File: rtl/fa_bit.sv
// One-bit full adder made of two half-adder stages; purely combinational.
// Zero latency, no flow control.
module fa_bit (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic carry
);

    logic ha0_sum;
    logic ha0_carry;
    logic ha1_carry;

    assign ha0_sum   = a ^ b;
    assign ha0_carry = a & b;
    assign sum       = ha0_sum ^ cin;
    assign ha1_carry = ha0_sum & cin;
    assign carry     = ha0_carry | ha1_carry;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one result bit per cycle, done pulses WIDTH+1 edges after start.
// start is ignored while busy; the result holds until the next accepted start.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] sum_sh;
    logic             carry_q;
    logic [CW-1:0]    cnt;
    logic             fa_sum;
    logic             fa_carry;
    logic             load;
    logic             step;

    fa_bit u_fa (
        .a     (a_sh[0]),
        .b     (b_sh[0]),
        .cin   (carry_q),
        .sum   (fa_sum),
        .carry (fa_carry)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        load      = 1'b0;
        step      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                step = 1'b1;
                if (cnt == LAST_CNT) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    load      = 1'b1;
                    state_nxt = RUN;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Sum bits enter at the MSB so the first (LSB) result bit lands at bit 0 after WIDTH steps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh    <= '0;
            b_sh    <= '0;
            sum_sh  <= '0;
            carry_q <= 1'b0;
            cnt     <= '0;
        end else if (load) begin
            a_sh    <= a;
            b_sh    <= b;
            carry_q <= 1'b0;
            cnt     <= '0;
        end else if (step) begin
            a_sh    <= {1'b0, a_sh[WIDTH-1:1]};
            b_sh    <= {1'b0, b_sh[WIDTH-1:1]};
            sum_sh  <= {fa_sum, sum_sh[WIDTH-1:1]};
            carry_q <= fa_carry;
            cnt     <= cnt + CW'(1);
        end
    end

    assign sum   = sum_sh;
    assign carry = carry_q;

endmodule

// File: tb/tb_serial_adder.sv
// Randomized and directed bench for serial_adder with a queue-based scoreboard.
module tb_serial_adder;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         carry;

    int errors = 0;
    int checks = 0;

    // Reference model: a start seen while no operation is pending is accepted and
    // occupies the next W edges; the result is the plain (W+1)-bit sum of operands.
    logic [W:0] exp_q[$];
    int         run_left = 0;
    logic       done_exp = 1'b0;

    serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .carry (carry)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            run_left = 0;
            done_exp = 1'b0;
            exp_q.delete();
        end else begin
            done_exp = (run_left == 1);
            if (run_left > 0) begin
                run_left--;
            end else if (start) begin
                exp_q.push_back({1'b0, a} + {1'b0, b});
                run_left = W;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            check("busy", busy, run_left > 0);
            check("done", done, done_exp);
            if (done) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL result_unexpected: got %0h with no pending operation", {carry, sum});
                end else begin
                    check("result", {carry, sum}, exp_q.pop_front());
                end
            end
        end
    end

    task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y);
        @(negedge clk);
        a     = x;
        b     = y;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a     = W'($urandom);
        b     = W'($urandom);
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!done && n < 4 * W) begin
            @(negedge clk);
            n++;
            if (busy) begin
                a = W'($urandom);
                b = W'($urandom);
            end
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL wait_done: timeout, done=%0b expected 1", done);
        end
    endtask

    initial begin
        int n;
        logic seen_done;
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        #1;
        check("reset_busy", busy, 1'b0);
        check("reset_done", done, 1'b0);
        check("reset_sum", sum, 8'h00);
        check("reset_carry", carry, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        issue(8'h0F, 8'h01);
        wait_done(n);
        check("latency", n, W);
        check("sum_0f_01", sum, 8'h10);
        check("carry_0f_01", carry, 1'b0);

        issue(8'hFF, 8'h01);
        wait_done(n);
        check("sum_ff_01", sum, 8'h00);
        check("carry_ff_01", carry, 1'b1);

        issue(8'hA5, 8'h5A);
        wait_done(n);
        check("sum_a5_5a", sum, 8'hFF);
        check("carry_a5_5a", carry, 1'b0);
        repeat (3) @(negedge clk);
        check("hold_sum", sum, 8'hFF);
        check("hold_carry", carry, 1'b0);

        // Second start while busy must be ignored.
        issue(8'h80, 8'h80);
        repeat (2) @(negedge clk);
        a     = 8'h01;
        b     = 8'h01;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(n);
        check("sum_ignored_start", sum, 8'h00);
        check("carry_ignored_start", carry, 1'b1);

        // Reset mid-run aborts without a done pulse.
        issue(8'h12, 8'h34);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_busy", busy, 1'b0);
        check("abort_done", done, 1'b0);
        check("abort_sum", sum, 8'h00);
        check("abort_carry", carry, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        seen_done = 1'b0;
        repeat (W + 2) begin
            @(negedge clk);
            if (done) seen_done = 1'b1;
        end
        check("no_done_after_abort", seen_done, 1'b0);
        issue(8'h03, 8'h04);
        wait_done(n);
        check("sum_after_reset", sum, 8'h07);

        // start held through DONE chains the next operation without IDLE.
        @(negedge clk);
        a     = 8'h11;
        b     = 8'h22;
        start = 1'b1;
        @(negedge clk);
        a     = 8'h10;
        b     = 8'h20;
        while (!done && n < 4 * W) begin
            @(negedge clk);
            n++;
        end
        n = 0;
        while (!done && n < 4 * W) begin
            @(negedge clk);
            n++;
        end
        check("chain_first_sum", sum, 8'h33);
        check("chain_first_carry", carry, 1'b0);
        @(negedge clk);
        start = 1'b0;
        check("chain_no_idle", busy, 1'b1);
        wait_done(n);
        check("chain_second_sum", sum, 8'h30);
        check("chain_second_carry", carry, 1'b0);

        for (int i = 0; i < 24; i++) begin
            issue(W'($urandom), W'($urandom));
            wait_done(n);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        repeat (W + 2) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the operand and result width in bits; legal range is 2..32.
REQ-002 Port clk, input, 1 bit, SHALL be the single clock; all state updates on its rising edge.
REQ-003 Port rst, input, 1 bit, SHALL be the asynchronous, active-high reset.
REQ-004 Port start, input, 1 bit, SHALL be the request to begin an addition; it is sampled on the clk rising edge.
REQ-005 Port a, input, WIDTH bits, SHALL be operand A, captured when start is accepted.
REQ-006 Port b, input, WIDTH bits, SHALL be operand B, captured when start is accepted.
REQ-007 Port busy, output, 1 bit, SHALL be high while an addition is in progress.
REQ-008 Port done, output, 1 bit, SHALL be a one-cycle pulse marking a valid result.
REQ-009 Port sum, output, WIDTH bits, SHALL be the result (a + b) mod 2^WIDTH.
REQ-010 Port carry, output, 1 bit, SHALL be the carry-out of a + b.

Function
REQ-011 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-012 start SHALL be accepted in IDLE or DONE: a and b load into shift registers, the carry flop clears, the bit counter is set to 0, and the state becomes RUN.
REQ-013 In RUN, each cycle SHALL add bit 0 of both shift registers plus the carry flop using one full-adder bit.
REQ-014 In each RUN cycle, the full-adder sum bit SHALL shift into the sum register MSB-first (right shift), the operands SHALL shift right, the carry flop SHALL take carry-out, and the counter SHALL increment.
REQ-015 After exactly WIDTH RUN cycles, the state SHALL become DONE.
REQ-016 If start is accepted at edge k, done SHALL be high for the single cycle after edge k+WIDTH, so latency is WIDTH+1 edges.
REQ-017 sum and carry SHALL be stable and valid from done until the next accepted start; the transition from DONE SHALL go to RUN if start is high, otherwise to IDLE.
REQ-018 busy SHALL be high exactly in RUN.
REQ-019 done SHALL be high exactly in DONE.
REQ-020 start while busy SHALL be ignored; the operation in flight and its operands SHALL be unaffected.
REQ-021 Changes on a or b outside the accepting edge SHALL have no effect.
REQ-022 The counter SHALL be clog2(WIDTH+1) bits wide and SHALL never wrap within an operation.

Reset
REQ-023 rst high SHALL immediately force IDLE, busy=0, done=0, sum=0, carry=0, counter=0 and operand registers=0, independent of clk.
REQ-024 Reset asserted mid-RUN SHALL abort the operation; no done pulse SHALL follow.
REQ-025 The first start after reset release SHALL behave as a normal start.

Structure
REQ-026 A shared package serial_adder_pkg SHALL hold the state encoding (IDLE=2'b00, RUN=2'b01, DONE=2'b10) and the WIDTH default constant.
REQ-027 One sub-module fa_bit SHALL be instantiated: a full adder (inputs a, b, cin; outputs sum, carry) built from two half-adder stages and an OR of their carries.
REQ-028 No other sub-modules SHALL be used.

Verification (WIDTH=8)
REQ-029 a=0x0F, b=0x01, start at edge 0 -> busy on edges 1..8, done high after edge 8 with sum=0x10, carry=0.
REQ-030 a=0xFF, b=0x01 -> sum=0x00, carry=1.
REQ-031 a=0xA5, b=0x5A -> sum=0xFF, carry=0.
REQ-032 Start 0x80+0x80, then start again with a=0x01 mid-RUN -> second start ignored; sum=0x00, carry=1.
REQ-033 rst pulsed at RUN cycle 4 -> outputs 0 within the same cycle and no done pulse; a new start with 0x03+0x04 -> sum=0x07.
REQ-034 start held high through DONE with new a=0x10, b=0x20 -> first result presented, next operation starts without IDLE, then done with sum=0x30, carry=0.
